// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative data cache.
// State enum, address-field width functions and the byte-strobe merge.
package dcache_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_WRITE,
    S_RESP
  } dcache_state_t;

  function automatic int off_w(input int lw);
    return $clog2(lw) + $clog2(WORD_BYTES);
  endfunction

  function automatic int idx_w(input int ns);
    return $clog2(ns);
  endfunction

  function automatic int tag_w(input int ns, input int lw);
    return 32 - idx_w(ns) - off_w(lw);
  endfunction

  function automatic logic [31:0] merge_strb(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < WORD_BYTES; b++)
      if (strb[b]) r[8*b+:8] = new_w[8*b+:8];
    return r;
  endfunction

endpackage

// File: rtl/dcache_way_ram.sv
// One cache way: per-set tag + valid, per-word data; sync write, async read.
// Ports: clk_i, reset_i, idx_i, rword_i -> rdata_o/tag_o/valid_o; dwe_i/wword_i/wdata_i, twe_i/wtag_i.
module dcache_way_ram import dcache_pkg::*; #(
  parameter int NUM_SETS   = 32,
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 22
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [$clog2(NUM_SETS)-1:0]   idx_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rword_i,
  output logic [31:0]                   rdata_o,
  output logic [TAG_W-1:0]              tag_o,
  output logic                          valid_o,
  input  logic                          dwe_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wword_i,
  input  logic [31:0]                   wdata_i,
  input  logic                          twe_i,
  input  logic [TAG_W-1:0]              wtag_i
);

  logic [31:0]         data_q [NUM_SETS][LINE_WORDS];
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;

  assign rdata_o = data_q[idx_i][rword_i];
  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (dwe_i) data_q[idx_i][wword_i] <= wdata_i;
    if (twe_i) tag_q[idx_i] <= wtag_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) valid_q <= '0;
    else if (twe_i) valid_q[idx_i] <= 1'b1;
  end

endmodule

// File: rtl/dcache_sa.sv
// N-way set-associative write-through data cache with burst line refill.
// CPU req/resp side, single-beat-per-ack memory bus; DCACHE_STATS_EN adds stat_hits/stat_misses.
module dcache_sa import dcache_pkg::*; #(
  parameter int NUM_SETS   = 32,
  parameter int NUM_WAYS   = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  output logic        cpu_req_ready,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic [31:0] cpu_rdata,
  output logic        cpu_resp_valid,
  output logic        hit,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(NUM_SETS);
  localparam int TAG_W  = tag_w(NUM_SETS, LINE_WORDS);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  dcache_state_t state_q, state_d;

  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic              we_q;
  logic [3:0]        wstrb_q;
  logic [WORD_W-1:0] beat_q;
  logic [WAY_W-1:0]  victim_q;
  logic [WAY_W-1:0]  rr_q [NUM_SETS];

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] off;
  logic [TAG_W-1:0]  tag;
  logic              unused;

  assign idx    = addr_q[OFF_W+:IDX_W];
  assign off    = addr_q[2+:WORD_W];
  assign tag    = addr_q[31-:TAG_W];
  assign unused = ^addr_q[1:0];

  logic accept, ack_ref, last;
  assign accept  = cpu_req && cpu_req_ready;
  assign ack_ref = (state_q == S_REFILL) && mem_ack;
  assign last    = ack_ref && (beat_q == WORD_W'(LINE_WORDS - 1));

  logic [31:0]         rd_data [NUM_WAYS];
  logic [TAG_W-1:0]    rd_tag  [NUM_WAYS];
  logic [NUM_WAYS-1:0] rd_valid, hit_vec, dwe, twe;
  logic                hit_any, has_inv;
  logic [WAY_W-1:0]    hit_way, inv_way;
  logic [WORD_W-1:0]   w_word;
  logic [31:0]         w_data;

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = rd_valid[w] && (rd_tag[w] == tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    // Descending scan so the lowest-numbered invalid way wins
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!rd_valid[w]) inv_way = WAY_W'(w);
    hit_any = |hit_vec;
    has_inv = ~&rd_valid;
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      dwe[w] = ((state_q == S_LOOKUP) && we_q && hit_vec[w])
            || (ack_ref && (victim_q == WAY_W'(w)));
      twe[w] = last && (victim_q == WAY_W'(w));
    end
  end

  assign w_word = (state_q == S_REFILL) ? beat_q : off;
  assign w_data = (state_q == S_REFILL) ? mem_rdata
                : merge_strb(rd_data[hit_way], wdata_q, wstrb_q);

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    dcache_way_ram #(
      .NUM_SETS   (NUM_SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W)
    ) u_ram (
      .clk_i   (clk),
      .reset_i (reset),
      .idx_i   (idx),
      .rword_i (off),
      .rdata_o (rd_data[w]),
      .tag_o   (rd_tag[w]),
      .valid_o (rd_valid[w]),
      .dwe_i   (dwe[w]),
      .wword_i (w_word),
      .wdata_i (w_data),
      .twe_i   (twe[w]),
      .wtag_i  (tag)
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (we_q)         state_d = S_WRITE;
        else if (hit_any) state_d = S_IDLE;
        else              state_d = S_REFILL;
      end
      S_REFILL: if (last) state_d = S_RESP;
      S_WRITE:  if (mem_ack) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_rdata      = '0;
    cpu_resp_valid = 1'b0;
    hit            = 1'b0;
    miss           = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wstrb      = '0;
    unique case (state_q)
      S_IDLE: cpu_req_ready = 1'b1;
      S_LOOKUP: begin
        hit  = hit_any;
        miss = !hit_any;
        if (!we_q && hit_any) begin
          cpu_resp_valid = 1'b1;
          cpu_rdata      = rd_data[hit_way];
        end
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:OFF_W], beat_q, 2'b00};
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
      end
      S_RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_rdata      = we_q ? 32'h0 : rdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      beat_q   <= '0;
      victim_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else begin
      if (accept) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
        wstrb_q <= cpu_wstrb;
      end
      if (state_q == S_LOOKUP && !we_q && !hit_any)
        victim_q <= has_inv ? inv_way : rr_q[idx];
      if (ack_ref) begin
        beat_q <= beat_q + 1'b1;
        // Requested word is forwarded from the bus, not re-read
        if (beat_q == off) rdata_q <= mem_rdata;
      end
      if (last && NUM_WAYS > 1) rr_q[idx] <= rr_q[idx] + 1'b1;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      if (hit && hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 1;
      if (miss && misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_dcache_sa.sv
// Directed self-checking bench for dcache_sa.
// Memory responder acks every beat; word at address a is 0x1000 + (a-0x1000)/4.
module tb_dcache_sa;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_req_ready, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_resp_valid, hit, miss;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int checks = 0;
  int errors = 0;

  int          nb;
  logic [31:0] log_addr  [16];
  logic        log_we    [16];
  logic [31:0] log_wdata [16];
  logic [3:0]  log_wstrb [16];

  always #5 clk = ~clk;

  dcache_sa dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_wstrb      (cpu_wstrb),
    .cpu_rdata      (cpu_rdata),
    .cpu_resp_valid (cpu_resp_valid),
    .hit            (hit),
    .miss           (miss),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
`endif
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    return 32'h1000 + ((a - 32'h1000) >> 2);
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    nb        = 0;
    forever begin
      @(negedge clk);
      mem_ack   = mem_req;
      mem_rdata = memval(mem_addr);
      if (mem_req && nb < 16) begin
        log_addr[nb]  = mem_addr;
        log_we[nb]    = mem_we;
        log_wdata[nb] = mem_wdata;
        log_wstrb[nb] = mem_wstrb;
        nb++;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_req(
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [3:0]  st,
    output logic        ok,
    output logic        sh,
    output logic        sm,
    output logic [31:0] rd,
    output int          lat
  );
    ok = 0; sh = 0; sm = 0; rd = '0; lat = 0;
    nb = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a;
    cpu_wdata = wd; cpu_wstrb = st;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      lat++;
      sh |= hit;
      sm |= miss;
      if (cpu_resp_valid) begin
        rd = cpu_rdata;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %0b exp 1", cpu_req_ready);
    end
    checks++;
    if ({mem_req, mem_we, cpu_resp_valid, hit, miss} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %05b exp 00000",
               {mem_req, mem_we, cpu_resp_valid, hit, miss});
    end
    checks++;
    if ({cpu_rdata, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      errors++; $display("FAIL reset_data got rdata %h addr %h exp 0", cpu_rdata, mem_addr);
    end
  endtask

  task automatic test_cold_load();
    logic ok, sh, sm; logic [31:0] rd; int lat; logic bad;
    run_req(1'b0, 32'h0000_1004, '0, '0, ok, sh, sm, rd, lat);
    checks++;
    if (!ok || sm !== 1'b1 || sh !== 1'b0) begin
      errors++; $display("FAIL cold_miss got ok %0b hit %0b miss %0b exp 1 0 1", ok, sh, sm);
    end
    checks++;
    if (nb !== 8) begin
      errors++; $display("FAIL cold_beats got %0d exp 8", nb);
    end
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (log_addr[k] !== 32'h1000 + 32'(4 * k) || log_we[k] !== 1'b0) bad = 1;
    checks++;
    if (bad) begin
      errors++; $display("FAIL cold_addrs got first %h last %h exp 1000..101c reads", log_addr[0], log_addr[7]);
    end
    checks++;
    if (rd !== 32'h0000_1001) begin
      errors++; $display("FAIL cold_rdata got %h exp 00001001", rd);
    end
    run_req(1'b0, 32'h0000_1008, '0, '0, ok, sh, sm, rd, lat);
    checks++;
    if (!ok || sh !== 1'b1 || sm !== 1'b0 || nb !== 0) begin
      errors++; $display("FAIL warm_hit got ok %0b hit %0b miss %0b beats %0d exp 1 1 0 0", ok, sh, sm, nb);
    end
    checks++;
    if (rd !== 32'h0000_1002) begin
      errors++; $display("FAIL warm_rdata got %h exp 00001002", rd);
    end
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL hit_latency got %0d exp 1", lat);
    end
  endtask

  task automatic test_store_hit();
    logic ok, sh, sm; logic [31:0] rd; int lat;
    run_req(1'b1, 32'h0000_1004, 32'hAABB_CCDD, 4'b0011, ok, sh, sm, rd, lat);
    checks++;
    if (!ok || sh !== 1'b1 || nb !== 1) begin
      errors++; $display("FAIL st_hit got ok %0b hit %0b beats %0d exp 1 1 1", ok, sh, nb);
    end
    checks++;
    if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h1004 ||
        log_wdata[0] !== 32'hAABB_CCDD || log_wstrb[0] !== 4'b0011) begin
      errors++;
      $display("FAIL st_bus got we %0b addr %h data %h strb %b exp 1 1004 aabbccdd 0011",
               log_we[0], log_addr[0], log_wdata[0], log_wstrb[0]);
    end
    run_req(1'b0, 32'h0000_1004, '0, '0, ok, sh, sm, rd, lat);
    checks++;
    if (!ok || sh !== 1'b1 || rd !== 32'h0000_CCDD) begin
      errors++; $display("FAIL st_merge got hit %0b rdata %h exp 1 0000ccdd", sh, rd);
    end
  endtask

  task automatic test_store_miss();
    logic ok, sh, sm; logic [31:0] rd; int lat;
    run_req(1'b1, 32'h0000_8000, 32'h1234_5678, 4'b1111, ok, sh, sm, rd, lat);
    checks++;
    if (!ok || sm !== 1'b1 || nb !== 1 || log_addr[0] !== 32'h8000 || log_we[0] !== 1'b1) begin
      errors++; $display("FAIL stm_bus got miss %0b beats %0d addr %h exp 1 1 8000", sm, nb, log_addr[0]);
    end
    run_req(1'b0, 32'h0000_8000, '0, '0, ok, sh, sm, rd, lat);
    checks++;
    if (!ok || sm !== 1'b1 || nb !== 8 || rd !== 32'h0000_2C00) begin
      errors++; $display("FAIL stm_noalloc got miss %0b beats %0d rdata %h exp 1 8 00002c00", sm, nb, rd);
    end
  endtask

  task automatic test_zero_strb();
    logic ok, sh, sm; logic [31:0] rd; int lat;
    run_req(1'b1, 32'h0000_1008, 32'hFFFF_FFFF, 4'b0000, ok, sh, sm, rd, lat);
    checks++;
    if (!ok || nb !== 1 || log_wstrb[0] !== 4'b0000) begin
      errors++; $display("FAIL zstrb_bus got ok %0b beats %0d strb %b exp 1 1 0000", ok, nb, log_wstrb[0]);
    end
    run_req(1'b0, 32'h0000_1008, '0, '0, ok, sh, sm, rd, lat);
    checks++;
    if (!ok || sh !== 1'b1 || rd !== 32'h0000_1002) begin
      errors++; $display("FAIL zstrb_data got hit %0b rdata %h exp 1 00001002", sh, rd);
    end
  endtask

  task automatic test_evict();
    logic ok, sh, sm; logic [31:0] rd; int lat;
    logic [31:0] addrs [5];
    logic [4:0] misses;
    addrs = '{32'h2000, 32'h2400, 32'h2800, 32'h2C00, 32'h3000};
    apply_reset();
    misses = '0;
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, addrs[i], '0, '0, ok, sh, sm, rd, lat);
      misses[i] = ok && sm && (rd === memval(addrs[i]));
    end
    checks++;
    if (misses !== 5'b11111) begin
      errors++; $display("FAIL evict_fill got %05b exp 11111", misses);
    end
    run_req(1'b0, 32'h2000, '0, '0, ok, sh, sm, rd, lat);
    checks++;
    if (!ok || sm !== 1'b1 || rd !== 32'h0000_1400) begin
      errors++; $display("FAIL evict_first got miss %0b rdata %h exp 1 00001400", sm, rd);
    end
    run_req(1'b0, 32'h2C00, '0, '0, ok, sh, sm, rd, lat);
    checks++;
    if (!ok || sh !== 1'b1 || rd !== 32'h0000_1700) begin
      errors++; $display("FAIL evict_fourth got hit %0b rdata %h exp 1 00001700", sh, rd);
    end
  endtask

  task automatic test_reset_mid_refill();
    logic ok, sh, sm; logic [31:0] rd; int lat;
    run_req(1'b0, 32'h0000_1004, '0, '0, ok, sh, sm, rd, lat);
    nb = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5000;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 50 && nb < 3; i++) @(negedge clk);
    checks++;
    if (nb < 3) begin
      errors++; $display("FAIL rst_mid_beats got %0d exp 3", nb);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || cpu_req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_bus got req %0b ready %0b exp 0 1", mem_req, cpu_req_ready);
    end
    reset = 1'b0;
    run_req(1'b0, 32'h0000_1004, '0, '0, ok, sh, sm, rd, lat);
    checks++;
    if (!ok || sm !== 1'b1 || rd !== 32'h0000_1001) begin
      errors++; $display("FAIL rst_mid_reload got miss %0b rdata %h exp 1 00001001", sm, rd);
    end
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    logic ok, sh, sm; logic [31:0] rd; int lat;
    logic [31:0] seq [5];
    seq = '{32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h2000};
    apply_reset();
    checks++;
    if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
      errors++; $display("FAIL stats_reset got %0d %0d exp 0 0", stat_hits, stat_misses);
    end
    for (int i = 0; i < 5; i++)
      run_req(1'b0, seq[i], '0, '0, ok, sh, sm, rd, lat);
    checks++;
    if (stat_hits !== 32'd3 || stat_misses !== 32'd2) begin
      errors++; $display("FAIL stats_count got %0d %0d exp 3 2", stat_hits, stat_misses);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_store_miss();
    test_zero_strb();
    test_evict();
    test_reset_mid_refill();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
